// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width and FSM state encodings.
package fetch_stage_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch statistics, instantiated by fetch_stage only when FETCH_PERF_EN is defined.
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_inc,
    input  logic        miss_inc,
    output logic [15:0] fetch_count,
    output logic [15:0] miss_cycles
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_count <= '0;
            miss_cycles <= '0;
        end else begin
            if (fetch_inc && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
            if (miss_inc && miss_cycles != 16'hFFFF) miss_cycles <= miss_cycles + 16'd1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: I-cache request/response FSM, one-word hold buffer and the IF/ID register.
// Optional statistics outputs (fetch_count, miss_cycles) are built when FETCH_PERF_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                   WORD_SIZE   = fetch_stage_pkg::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] BUBBLE_INST = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] pc_next_seq,
    input  logic                 flush,
    input  logic                 id_stall,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    output logic                 if_stall,
    output logic                 IF_ID_valid,
    output logic [WORD_SIZE-1:0] IF_ID_inst,
    output logic [WORD_SIZE-1:0] IF_ID_PC,
    output logic [WORD_SIZE-1:0] IF_ID_PC_next_seq
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]          fetch_count,
    output logic [15:0]          miss_cycles
`endif
);

    fetch_state_t         state, state_next;
    logic [WORD_SIZE-1:0] req_pc, req_pc_next;
    logic [WORD_SIZE-1:0] hold_inst;

    logic                 load;
    logic                 bubble;
    logic                 capture_hold;
    logic [WORD_SIZE-1:0] load_inst, load_pc, load_pc_next;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        i_readM      = 1'b0;
        i_address    = req_pc;
        if_stall     = 1'b0;
        load         = 1'b0;
        bubble       = 1'b0;
        capture_hold = 1'b0;
        load_inst    = hold_inst;
        load_pc      = req_pc;
        load_pc_next = req_pc_next;

        unique case (state)
            S_REQ: begin
                i_readM      = 1'b1;
                i_address    = pc;
                load_inst    = i_data;
                load_pc      = pc;
                load_pc_next = pc_next_seq;
                if (flush) begin
                    bubble = 1'b1;
                end else if (i_ready && !id_stall) begin
                    load = 1'b1;
                end else if (i_ready) begin
                    capture_hold = 1'b1;
                    if_stall     = 1'b1;
                    state_next   = S_HOLD;
                end else begin
                    if_stall   = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                i_readM   = 1'b1;
                load_inst = i_data;
                if (flush) begin
                    // The cache cannot cancel, so an unanswered request must be drained.
                    bubble     = 1'b1;
                    state_next = i_ready ? S_REQ : S_DRAIN;
                end else if (i_ready && !id_stall) begin
                    load       = 1'b1;
                    state_next = S_REQ;
                end else if (i_ready) begin
                    capture_hold = 1'b1;
                    if_stall     = 1'b1;
                    state_next   = S_HOLD;
                end else begin
                    if_stall = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    bubble     = 1'b1;
                    state_next = S_REQ;
                end else if (id_stall) begin
                    if_stall = 1'b1;
                end else begin
                    load       = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                i_readM  = 1'b1;
                if_stall = 1'b1;
                if (i_ready) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= S_REQ;
            req_pc            <= '0;
            req_pc_next       <= '0;
            IF_ID_valid       <= 1'b0;
            IF_ID_inst        <= BUBBLE_INST;
            IF_ID_PC          <= '0;
            IF_ID_PC_next_seq <= '0;
        end else begin
            state <= state_next;
            if (state == S_REQ) begin
                req_pc      <= pc;
                req_pc_next <= pc_next_seq;
            end
            // Once ID has consumed the word and nothing new arrives, a bubble is presented.
            if (bubble || (!load && !id_stall)) begin
                IF_ID_valid <= 1'b0;
                IF_ID_inst  <= BUBBLE_INST;
            end else if (load) begin
                IF_ID_valid       <= 1'b1;
                IF_ID_inst        <= load_inst;
                IF_ID_PC          <= load_pc;
                IF_ID_PC_next_seq <= load_pc_next;
            end
        end
    end

    // NOTE: the hold buffer is data-only and left unreset; its occupancy is encoded by S_HOLD.
    always_ff @(posedge clk) begin
        if (capture_hold) hold_inst <= i_data;
    end

`ifdef FETCH_PERF_EN
    fetch_perf_counters u_perf (
        .clk         (clk),
        .reset_n     (reset_n),
        .fetch_inc   (load),
        .miss_inc    (state == S_WAIT || state == S_DRAIN),
        .fetch_count (fetch_count),
        .miss_cycles (miss_cycles)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus an IF/ID scoreboard queue.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc, pc_next_seq, i_data, i_address;
    logic        flush, id_stall, i_ready, i_readM, if_stall;
    logic        IF_ID_valid;
    logic [15:0] IF_ID_inst, IF_ID_PC, IF_ID_PC_next_seq;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count, miss_cycles;
    logic [15:0] fc0, mc0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pc                (pc),
        .pc_next_seq       (pc_next_seq),
        .flush             (flush),
        .id_stall          (id_stall),
        .i_readM           (i_readM),
        .i_address         (i_address),
        .i_data            (i_data),
        .i_ready           (i_ready),
        .if_stall          (if_stall),
        .IF_ID_valid       (IF_ID_valid),
        .IF_ID_inst        (IF_ID_inst),
        .IF_ID_PC          (IF_ID_PC),
        .IF_ID_PC_next_seq (IF_ID_PC_next_seq)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count       (fetch_count),
        .miss_cycles       (miss_cycles)
`endif
    );

    typedef struct {
        logic         flush, id_stall, i_ready;
        logic [15:0]  pc, data;
        logic         exp_readM;
        logic [15:0]  exp_addr;
        logic         exp_stall, exp_load, exp_valid;
        logic [15:0]  exp_inst, exp_ifpc;
        fetch_state_t exp_state;
    } vec_t;

    typedef struct {
        logic [15:0] inst, pc, pc_next;
    } ifid_t;

    vec_t  vecs[$];
    ifid_t sb[$];
    ifid_t last_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic fl, st, rdy, input logic [15:0] p, d,
                                input logic rd, input logic [15:0] a, input logic s, ld, v,
                                input logic [15:0] inst, ifpc, input fetch_state_t es);
        vec_t r;
        r.flush = fl; r.id_stall = st; r.i_ready = rdy; r.pc = p; r.data = d;
        r.exp_readM = rd; r.exp_addr = a; r.exp_stall = s; r.exp_load = ld; r.exp_valid = v;
        r.exp_inst = inst; r.exp_ifpc = ifpc; r.exp_state = es;
        return r;
    endfunction

    initial begin
        //               fl st rdy pc      data      rd addr    stl ld v  inst      ifpc    state
        // hits at pc 0..3, one instruction per cycle
        vecs.push_back(mk(0, 0, 1, 16'd0,  16'hA000, 1, 16'd0,  0, 1, 1, 16'hA000, 16'd0,  S_REQ));
        vecs.push_back(mk(0, 0, 1, 16'd1,  16'hA001, 1, 16'd1,  0, 1, 1, 16'hA001, 16'd1,  S_REQ));
        vecs.push_back(mk(0, 0, 1, 16'd2,  16'hA002, 1, 16'd2,  0, 1, 1, 16'hA002, 16'd2,  S_REQ));
        vecs.push_back(mk(0, 0, 1, 16'd3,  16'hA003, 1, 16'd3,  0, 1, 1, 16'hA003, 16'd3,  S_REQ));
        // miss at pc 5, response three cycles after the request (indices 4..7)
        vecs.push_back(mk(0, 0, 0, 16'd5,  16'h0000, 1, 16'd5,  1, 0, 0, 16'h0,    16'd0,  S_WAIT));
        vecs.push_back(mk(0, 0, 0, 16'd5,  16'h0000, 1, 16'd5,  1, 0, 0, 16'h0,    16'd0,  S_WAIT));
        vecs.push_back(mk(0, 0, 0, 16'd5,  16'h0000, 1, 16'd5,  1, 0, 0, 16'h0,    16'd0,  S_WAIT));
        vecs.push_back(mk(0, 0, 1, 16'd5,  16'hB005, 1, 16'd5,  0, 1, 1, 16'hB005, 16'd5,  S_REQ));
        // hit at pc 8 while ID holds for two cycles
        vecs.push_back(mk(0, 1, 1, 16'd8,  16'hC008, 1, 16'd8,  1, 0, 1, 16'h0,    16'd0,  S_HOLD));
        vecs.push_back(mk(0, 1, 0, 16'd8,  16'h0000, 0, 16'd8,  1, 0, 1, 16'h0,    16'd0,  S_HOLD));
        vecs.push_back(mk(0, 0, 0, 16'd8,  16'h0000, 0, 16'd8,  0, 1, 1, 16'hC008, 16'd8,  S_REQ));
        // flush during a miss at pc 9, redirect to 20; flush inside S_DRAIN is ignored
        vecs.push_back(mk(0, 0, 0, 16'd9,  16'h0000, 1, 16'd9,  1, 0, 0, 16'h0,    16'd0,  S_WAIT));
        vecs.push_back(mk(1, 0, 0, 16'd9,  16'h0000, 1, 16'd9,  0, 0, 0, 16'h0,    16'd0,  S_DRAIN));
        vecs.push_back(mk(0, 0, 0, 16'd20, 16'h0000, 1, 16'd9,  1, 0, 0, 16'h0,    16'd0,  S_DRAIN));
        vecs.push_back(mk(1, 0, 1, 16'd20, 16'hDEAD, 1, 16'd9,  1, 0, 0, 16'h0,    16'd0,  S_REQ));
        vecs.push_back(mk(0, 0, 1, 16'd20, 16'hA014, 1, 16'd20, 0, 1, 1, 16'hA014, 16'd20, S_REQ));
        // flush on a hit, flush beating id_stall, flush out of S_HOLD
        vecs.push_back(mk(1, 0, 1, 16'd21, 16'hA015, 1, 16'd21, 0, 0, 0, 16'h0,    16'd0,  S_REQ));
        vecs.push_back(mk(0, 0, 1, 16'd22, 16'hA016, 1, 16'd22, 0, 1, 1, 16'hA016, 16'd22, S_REQ));
        vecs.push_back(mk(1, 1, 1, 16'd30, 16'hA01E, 1, 16'd30, 0, 0, 0, 16'h0,    16'd0,  S_REQ));
        vecs.push_back(mk(0, 1, 1, 16'd31, 16'hA01F, 1, 16'd31, 1, 0, 0, 16'h0,    16'd0,  S_HOLD));
        vecs.push_back(mk(1, 1, 0, 16'd31, 16'h0000, 0, 16'd31, 0, 0, 0, 16'h0,    16'd0,  S_REQ));
        vecs.push_back(mk(0, 0, 1, 16'd40, 16'hA028, 1, 16'd40, 0, 1, 1, 16'hA028, 16'd40, S_REQ));
        // flush in S_WAIT coinciding with the response: the word is discarded
        vecs.push_back(mk(0, 0, 0, 16'd41, 16'h0000, 1, 16'd41, 1, 0, 0, 16'h0,    16'd0,  S_WAIT));
        vecs.push_back(mk(1, 0, 1, 16'd41, 16'hDEAD, 1, 16'd41, 0, 0, 0, 16'h0,    16'd0,  S_REQ));
        vecs.push_back(mk(0, 0, 1, 16'd50, 16'hA032, 1, 16'd50, 0, 1, 1, 16'hA032, 16'd50, S_REQ));
        // miss whose response meets an ID hold: S_WAIT -> S_HOLD -> S_REQ
        vecs.push_back(mk(0, 0, 0, 16'd51, 16'h0000, 1, 16'd51, 1, 0, 0, 16'h0,    16'd0,  S_WAIT));
        vecs.push_back(mk(0, 1, 1, 16'd51, 16'hC033, 1, 16'd51, 1, 0, 0, 16'h0,    16'd0,  S_HOLD));
        vecs.push_back(mk(0, 0, 0, 16'd51, 16'h0000, 0, 16'd51, 0, 1, 1, 16'hC033, 16'd51, S_REQ));

        reset_n = 1'b0; flush = 1'b0; id_stall = 1'b0; i_ready = 1'b0;
        pc = 16'd0; pc_next_seq = 16'd1; i_data = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid",   32'(IF_ID_valid),       32'd0);
        check("reset_inst",    32'(IF_ID_inst),        32'h0);
        check("reset_pc",      32'(IF_ID_PC),          32'd0);
        check("reset_pc_next", 32'(IF_ID_PC_next_seq), 32'd0);
        check("reset_state",   32'(dut.state),         32'(S_REQ));
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            flush = vecs[i].flush; id_stall = vecs[i].id_stall; i_ready = vecs[i].i_ready;
            pc = vecs[i].pc; pc_next_seq = vecs[i].pc + 16'd1; i_data = vecs[i].data;
`ifdef FETCH_PERF_EN
            if (i == 4) begin fc0 = fetch_count; mc0 = miss_cycles; end
`endif
            #1;
            check($sformatf("v%0d_readM", i), 32'(i_readM),   32'(vecs[i].exp_readM));
            check($sformatf("v%0d_addr", i),  32'(i_address), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_stall", i), 32'(if_stall),  32'(vecs[i].exp_stall));
            if (vecs[i].exp_load)
                sb.push_back('{inst: vecs[i].exp_inst, pc: vecs[i].exp_ifpc,
                               pc_next: vecs[i].exp_ifpc + 16'd1});
            @(posedge clk); #1;
            check($sformatf("v%0d_state", i), 32'(dut.state),   32'(vecs[i].exp_state));
            check($sformatf("v%0d_valid", i), 32'(IF_ID_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_load) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL v%0d_scoreboard: got empty queue, expected an entry", i);
                end else begin
                    last_exp = sb.pop_front();
                end
            end
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_inst", i),    32'(IF_ID_inst),        32'(last_exp.inst));
                check($sformatf("v%0d_ifpc", i),    32'(IF_ID_PC),          32'(last_exp.pc));
                check($sformatf("v%0d_pc_next", i), 32'(IF_ID_PC_next_seq), 32'(last_exp.pc_next));
            end else begin
                check($sformatf("v%0d_bubble", i),  32'(IF_ID_inst),        32'h0);
            end
`ifdef FETCH_PERF_EN
            if (i == 7) begin
                check("perf_miss_cycles", 32'(miss_cycles - mc0), 32'd3);
                check("perf_fetch_count", 32'(fetch_count - fc0), 32'd1);
            end
`endif
            @(negedge clk);
        end

        // Reset while a miss is outstanding, with a response and a flush arriving in the reset cycle.
        flush = 1'b0; id_stall = 1'b0; i_ready = 1'b0; pc = 16'd60; pc_next_seq = 16'd61;
        @(posedge clk); #1;
        check("rst_pre_state", 32'(dut.state), 32'(S_WAIT));
        @(negedge clk);
        reset_n = 1'b0; pc = 16'd0; pc_next_seq = 16'd1; i_ready = 1'b1; i_data = 16'hBEEF; flush = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", 32'(IF_ID_valid), 32'd0);
        check("rst_mid_inst",  32'(IF_ID_inst),  32'h0);
        check("rst_mid_state", 32'(dut.state),   32'(S_REQ));
        @(negedge clk);
        reset_n = 1'b1; i_ready = 1'b0; flush = 1'b0;
        #1;
        check("rst_mid_readM", 32'(i_readM),   32'd1);
        check("rst_mid_addr",  32'(i_address), 32'd0);
        check("sb_drained",    32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
